// File: rtl/hcsr04_echo_model.sv
// HC-SR04 ultrasonic sensor emulator: validates the trigger pulse width,
// waits a fixed burst delay, then drives echo high for a time proportional
// to the programmed target distance, followed by a dead-time holdoff.
// BURST_DLY, HOLDOFF, CYCLES_PER_CM and TIMEOUT_CYC are expected to be >= 1.
module hcsr04_echo_model #(
   parameter int unsigned MIN_TRIG      = 1000,
   parameter int unsigned BURST_DLY     = 500,
   parameter int unsigned CYCLES_PER_CM = 5800,
   parameter int unsigned MAX_CM        = 400,
   parameter int unsigned TIMEOUT_CYC   = 3800000,
   parameter int unsigned HOLDOFF       = 6000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trigger,
   input  logic [8:0] distance_cm,
   output logic       echo,
   output logic       busy,
   output logic       short_trig,
   output logic       ignored_trig
);

   // High-time counter only needs to reach MIN_TRIG, where it saturates.
   localparam int unsigned HW = $clog2(MIN_TRIG + 1);

   localparam logic [HW-1:0] MIN_C     = HW'(MIN_TRIG);
   localparam logic [31:0]   BURST_C   = 32'(BURST_DLY);
   localparam logic [31:0]   CPC_C     = 32'(CYCLES_PER_CM);
   localparam logic [31:0]   MAX_C     = 32'(MAX_CM);
   localparam logic [31:0]   TIMEOUT_C = 32'(TIMEOUT_CYC);
   localparam logic [31:0]   HOLD_C    = 32'(HOLDOFF);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_BURST,
      S_ECHO,
      S_HOLD
   } state_e;

   state_e          state_q, state_d;
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic [31:0]     cnt_q, cnt_d;
   logic [31:0]     w_q, w_d;
   logic            trig_dly_q;
   logic            echo_q, echo_d;
   logic            busy_q, busy_d;
   logic            short_q, short_d;
   logic            ign_q, ign_d;

   logic            trig_ok;
   logic            in_range;
   logic [31:0]     w_calc;
   logic            busy_state;

   // Pulse is long enough once the saturating high count reaches MIN_TRIG.
   assign trig_ok  = (hcnt_q >= MIN_C);

   // Echo width for the live distance; only sampled at trigger acceptance.
   assign in_range = (distance_cm != 9'd0) && (32'(distance_cm) <= MAX_C);
   assign w_calc   = in_range ? (32'(distance_cm) * CPC_C) : TIMEOUT_C;

   assign busy_state = (state_q == S_BURST) || (state_q == S_ECHO) ||
                       (state_q == S_HOLD);

   // State, counters and registered outputs; reset aborts any echo at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         hcnt_q     <= '0;
         cnt_q      <= '0;
         w_q        <= '0;
         trig_dly_q <= 1'b0;
         echo_q     <= 1'b0;
         busy_q     <= 1'b0;
         short_q    <= 1'b0;
         ign_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         cnt_q      <= cnt_d;
         w_q        <= w_d;
         trig_dly_q <= trigger;
         echo_q     <= echo_d;
         busy_q     <= busy_d;
         short_q    <= short_d;
         ign_q      <= ign_d;
      end
   end

   // Next-state and counter update. Phase counters are loaded with their
   // length and the phase ends on the cycle the count is 1.
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      unique case (state_q)
         S_IDLE: begin
            if (trigger) begin
               state_d = S_TRIG;
               hcnt_d  = HW'(1);
            end
         end
         S_TRIG: begin
            if (trigger) begin
               if (hcnt_q < MIN_C) hcnt_d = hcnt_q + 1'b1;
            end else if (trig_ok) begin
               state_d = S_BURST;
               w_d     = w_calc;
               cnt_d   = BURST_C;
               hcnt_d  = '0;
            end else begin
               state_d = S_IDLE;
               hcnt_d  = '0;
            end
         end
         S_BURST: begin
            if (cnt_q <= 32'd1) begin
               state_d = S_ECHO;
               cnt_d   = w_q;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_ECHO: begin
            if (cnt_q <= 32'd1) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_C;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q <= 32'd1) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            hcnt_d  = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode; registered so echo/busy track the state being entered.
   always_comb begin
      echo_d  = (state_d == S_ECHO);
      busy_d  = (state_d == S_BURST) || (state_d == S_ECHO) ||
                (state_d == S_HOLD);
      short_d = (state_q == S_TRIG) && !trigger && !trig_ok;
      ign_d   = busy_state && trigger && !trig_dly_q;
   end

   assign echo         = echo_q;
   assign busy         = busy_q;
   assign short_trig   = short_q;
   assign ignored_trig = ign_q;

endmodule
